alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
Issue stage directly upstream of the ALU. It holds the 32-entry integer register file and accepts decoded instructions. It resolves operands A and B, with forwarding from the ALU result and the writeback port. It registers A, B and alu_op into a one-deep pipeline register that drives the ALU inputs, using a valid/ready handshake on both sides.

Parameters:
XLEN, 32, data width of registers and operands
NREG, 32, number of architectural registers (x0 hardwired zero)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard in-flight and incoming instruction
dec_valid  in  1  decoded instruction present
dec_ready  out  1  stage can accept instruction
dec_rs1  in  5  source register 1 index
dec_rs2  in  5  source register 2 index
dec_rd  in  5  destination register index
dec_imm  in  XLEN  sign-extended immediate
dec_use_imm  in  1  B operand = immediate instead of rs2
dec_alu_op  in  3  ALU opcode (0 add, 1 sub, 2 xor, 3 or, 4 and, 5 pass B)
dec_reg_we  in  1  instruction writes rd
wb_we  in  1  writeback write enable
wb_rd  in  5  writeback register index
wb_data  in  XLEN  writeback data
alu_result  in  XLEN  current ALU result (combinational from ALU)
ex_valid  out  1  A/B/alu_op valid for ALU
ex_ready  in  1  downstream consumes current ALU operation
A  out  XLEN  ALU operand A
B  out  XLEN  ALU operand B
alu_op  out  3  ALU opcode
ex_rd  out  5  destination of in-flight op
ex_reg_we  out  1  in-flight op writes rd

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, A=0, B=0, alu_op=0, ex_rd=0, ex_reg_we=0, all registers=0.
- dec_ready = !ex_valid || ex_ready. This is combinational and does not depend on dec_valid.
- load = dec_valid && dec_ready && !flush. On load, the stage registers the resolved A, B, dec_alu_op, dec_rd and dec_reg_we, and ex_valid becomes 1 the next cycle. Latency is 1 cycle.
- No load and ex_ready=1: ex_valid becomes 0. The payload registers hold their values.
- No load and ex_ready=0: all outputs hold.
- flush=1: ex_valid becomes 0 next cycle and the incoming instruction is dropped. flush has priority over load. The register file is not affected.
- Register file: written on rising edge when wb_we && wb_rd!=0. Writes are independent of stall and flush. A write to x0 is ignored, and reads of x0 return 0.
- Operand resolution for each rs (rs1 and rs2), highest priority first:
  1. rs==0 gives 0.
  2. EX hit: ex_valid && ex_ready && ex_reg_we && ex_rd==rs gives alu_result.
  3. WB hit: wb_we && wb_rd==rs gives wb_data (same-cycle bypass).
  4. Otherwise the register file value.
- A = resolved rs1. B = dec_use_imm ? dec_imm : resolved rs2.
- alu_op values 6 and 7 pass through unchanged; the ALU treats them as add.
- The EX hit requires ex_ready=1 because the downstream stage commits the result that cycle. If ex_ready=0, no load occurs.

Optional Feature:
- Macro ALU_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0]. It increments each cycle dec_valid && !dec_ready, saturates at 0xFFFFFFFF, resets to 0 on rst_n, and is not cleared by flush.
- Undefined: no port, no counter logic.

Decomposition:
- Package alu_pkg: alu_op_e enum (ALU_ADD=0, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_PASSB), XLEN and REG_IDX_W=5 constants.
- Sub-module regfile: 2 read ports, 1 write port, x0 hardwired, async reset to zero, no internal bypass.
- Forwarding mux and pipeline register stay in alu_operand_stage.

Test Plan:
- Reset mid-operation: assert rst_n=0 while ex_valid=1 -> ex_valid=0, A=B=0, and reading any register returns 0.
- WB bypass: wb_we=1, wb_rd=3, wb_data=10, same cycle as issuing rs1=3 with dec_use_imm=1, imm=7, op=1 -> next cycle A=10, B=7, alu_op=1, ex_valid=1.
- EX forward: issue x5=A+B with A=10, B=7, then immediately issue rs1=5, rs2=5 with ex_ready=1 and alu_result=17 -> A=17, B=17.
- Backpressure: ex_ready=0 for 3 cycles with dec_valid=1 -> dec_ready=0 and outputs hold. With ALU_STALL_CNT_EN, stall_cnt=3.
- Flush: flush=1 with dec_valid=1 and ex_valid=1 -> ex_valid=0 next cycle. Outstanding wb_we to x4 still lands, so a later read of x4 returns wb_data.
- x0: wb_we=1, wb_rd=0, wb_data=0xFFFFFFFF, then issue rs1=0, rs2=0 -> A=0, B=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand issue stage.
package alu_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_XOR   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_AND   = 3'd4,
        ALU_PASSB = 3'd5
    } alu_op_e;

endpackage

// File: rtl/alu_operand_stage_regfile.sv
// Integer register file: two async read ports, one write port, x0 reads as zero.
module regfile
    import alu_pkg::*;
#(
    parameter int XLEN = alu_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [REG_IDX_W-1:0] raddr1,
    input  logic [REG_IDX_W-1:0] raddr2,
    output logic [XLEN-1:0]      rdata1,
    output logic [XLEN-1:0]      rdata2
);

    logic [XLEN-1:0] r_regs [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (waddr != '0) && (int'(waddr) < NREG)) begin
            r_regs[waddr] <= wdata;
        end
    end

    // Entry 0 may hold nothing useful; the architectural zero comes from here.
    assign rdata1 = ((raddr1 == '0) || (int'(raddr1) >= NREG)) ? '0 : r_regs[raddr1];
    assign rdata2 = ((raddr2 == '0) || (int'(raddr2) >= NREG)) ? '0 : r_regs[raddr2];

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the ALU: register file, operand forwarding and a one-deep EX register.
// Optional stall counter output enabled by defining ALU_STALL_CNT_EN.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN = alu_pkg::XLEN,
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [REG_IDX_W-1:0] dec_rs1,
    input  logic [REG_IDX_W-1:0] dec_rs2,
    input  logic [REG_IDX_W-1:0] dec_rd,
    input  logic [XLEN-1:0]      dec_imm,
    input  logic                 dec_use_imm,
    input  logic [2:0]           dec_alu_op,
    input  logic                 dec_reg_we,
    input  logic                 wb_we,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic [XLEN-1:0]      alu_result,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [XLEN-1:0]      A,
    output logic [XLEN-1:0]      B,
    output logic [2:0]           alu_op,
    output logic [REG_IDX_W-1:0] ex_rd,
`ifdef ALU_STALL_CNT_EN
    output logic [31:0]          stall_cnt,
`endif
    output logic                 ex_reg_we
);

    logic                 r_ex_valid;
    logic [XLEN-1:0]      r_a;
    logic [XLEN-1:0]      r_b;
    logic [2:0]           r_alu_op;
    logic [REG_IDX_W-1:0] r_ex_rd;
    logic                 r_ex_reg_we;

    logic [XLEN-1:0]      w_rf_rdata1;
    logic [XLEN-1:0]      w_rf_rdata2;
    logic [XLEN-1:0]      w_rs1_val;
    logic [XLEN-1:0]      w_rs2_val;
    logic [XLEN-1:0]      w_op_b;
    logic                 w_ex_fwd;
    logic                 w_load;

    regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (dec_rs1),
        .raddr2 (dec_rs2),
        .rdata1 (w_rf_rdata1),
        .rdata2 (w_rf_rdata2)
    );

    assign dec_ready = !r_ex_valid || ex_ready;
    assign w_load    = dec_valid && dec_ready && !flush;

    // The ALU result is only forwardable in the cycle downstream commits it.
    assign w_ex_fwd  = r_ex_valid && ex_ready && r_ex_reg_we;

    always_comb begin
        w_rs1_val = w_rf_rdata1;
        if (dec_rs1 == '0) begin
            w_rs1_val = '0;
        end else if (w_ex_fwd && (r_ex_rd == dec_rs1)) begin
            w_rs1_val = alu_result;
        end else if (wb_we && (wb_rd == dec_rs1)) begin
            w_rs1_val = wb_data;
        end

        w_rs2_val = w_rf_rdata2;
        if (dec_rs2 == '0) begin
            w_rs2_val = '0;
        end else if (w_ex_fwd && (r_ex_rd == dec_rs2)) begin
            w_rs2_val = alu_result;
        end else if (wb_we && (wb_rd == dec_rs2)) begin
            w_rs2_val = wb_data;
        end

        w_op_b = dec_use_imm ? dec_imm : w_rs2_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_alu_op    <= 3'd0;
            r_ex_rd     <= '0;
            r_ex_reg_we <= 1'b0;
        end else if (flush) begin
            r_ex_valid  <= 1'b0;
        end else if (w_load) begin
            r_ex_valid  <= 1'b1;
            r_a         <= w_rs1_val;
            r_b         <= w_op_b;
            r_alu_op    <= dec_alu_op;
            r_ex_rd     <= dec_rd;
            r_ex_reg_we <= dec_reg_we;
        end else if (ex_ready) begin
            r_ex_valid  <= 1'b0;
        end
    end

`ifdef ALU_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles an offered instruction was refused; flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (dec_valid && !dec_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign ex_valid  = r_ex_valid;
    assign A         = r_a;
    assign B         = r_b;
    assign alu_op    = r_alu_op;
    assign ex_rd     = r_ex_rd;
    assign ex_reg_we = r_ex_reg_we;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage (define ALU_STALL_CNT_EN to cover the stall counter).
module tb_alu_operand_stage;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic [31:0] dec_imm;
    logic        dec_use_imm;
    logic [2:0]  dec_alu_op;
    logic        dec_reg_we;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] alu_result;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  alu_op;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
`ifdef ALU_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    alu_operand_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_imm     (dec_imm),
        .dec_use_imm (dec_use_imm),
        .dec_alu_op  (dec_alu_op),
        .dec_reg_we  (dec_reg_we),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .alu_result  (alu_result),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .A           (A),
        .B           (B),
        .alu_op      (alu_op),
        .ex_rd       (ex_rd),
`ifdef ALU_STALL_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .ex_reg_we   (ex_reg_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush       = 1'b0;
        dec_valid   = 1'b0;
        dec_rs1     = 5'd0;
        dec_rs2     = 5'd0;
        dec_rd      = 5'd0;
        dec_imm     = 32'd0;
        dec_use_imm = 1'b0;
        dec_alu_op  = 3'd0;
        dec_reg_we  = 1'b0;
        wb_we       = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 32'd0;
        alu_result  = 32'd0;
        ex_ready    = 1'b1;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic use_imm, input logic [31:0] imm, input logic [2:0] op,
                         input logic reg_we);
        dec_valid   = 1'b1;
        dec_rs1     = rs1;
        dec_rs2     = rs2;
        dec_rd      = rd;
        dec_use_imm = use_imm;
        dec_imm     = imm;
        dec_alu_op  = op;
        dec_reg_we  = reg_we;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ex_valid got %0b want 0", ex_valid); end
        checks++; if (A !== 32'd0) begin errors++; $display("[TB] FAIL reset_A got %08h want 00000000", A); end
        checks++; if (B !== 32'd0) begin errors++; $display("[TB] FAIL reset_B got %08h want 00000000", B); end
        checks++; if (alu_op !== 3'd0) begin errors++; $display("[TB] FAIL reset_alu_op got %0d want 0", alu_op); end
        checks++; if (ex_rd !== 5'd0 || ex_reg_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_ex_rd got rd=%0d we=%0b want 0/0", ex_rd, ex_reg_we); end
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_dec_ready got %0b want 1", dec_ready); end
`ifdef ALU_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
`endif
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_wb_bypass();
        issue(5'd3, 5'd0, 5'd6, 1'b1, 32'd7, ALU_SUB, 1'b1);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'd10;
        step();
        idle();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL wb_bypass_valid got %0b want 1", ex_valid); end
        checks++; if (A !== 32'd10) begin errors++; $display("[TB] FAIL wb_bypass_A got %0d want 10", A); end
        checks++; if (B !== 32'd7) begin errors++; $display("[TB] FAIL wb_bypass_B got %0d want 7", B); end
        checks++; if (alu_op !== 3'd1) begin errors++; $display("[TB] FAIL wb_bypass_op got %0d want 1", alu_op); end
        checks++; if (ex_rd !== 5'd6 || ex_reg_we !== 1'b1) begin errors++; $display("[TB] FAIL wb_bypass_rd got rd=%0d we=%0b want 6/1", ex_rd, ex_reg_we); end
    endtask

    task automatic test_ex_forward();
        // x3 now holds 10 in the register file; this op is x5 = x3 + 7.
        issue(5'd3, 5'd0, 5'd5, 1'b1, 32'd7, ALU_ADD, 1'b1);
        step();
        checks++; if (A !== 32'd10 || B !== 32'd7) begin errors++; $display("[TB] FAIL ex_fwd_first got A=%0d B=%0d want 10/7", A, B); end
        issue(5'd5, 5'd5, 5'd8, 1'b0, 32'd0, ALU_XOR, 1'b1);
        alu_result = 32'd17;
        ex_ready   = 1'b1;
        step();
        checks++; if (A !== 32'd17) begin errors++; $display("[TB] FAIL ex_fwd_A got %0d want 17", A); end
        checks++; if (B !== 32'd17) begin errors++; $display("[TB] FAIL ex_fwd_B got %0d want 17", B); end
        checks++; if (alu_op !== 3'd2 || ex_rd !== 5'd8) begin errors++; $display("[TB] FAIL ex_fwd_op got op=%0d rd=%0d want 2/8", alu_op, ex_rd); end
        alu_result = 32'd0;
    endtask

    task automatic test_backpressure();
        issue(5'd3, 5'd0, 5'd9, 1'b1, 32'd5, ALU_AND, 1'b0);
        ex_ready = 1'b0;
        #1;
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_dec_ready got %0b want 0", dec_ready); end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (ex_valid !== 1'b1 || A !== 32'd17 || B !== 32'd17 || alu_op !== 3'd2 || dec_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d got v=%0b A=%0d B=%0d op=%0d rdy=%0b want 1/17/17/2/0",
                         c, ex_valid, A, B, alu_op, dec_ready);
            end
        end
`ifdef ALU_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("[TB] FAIL bp_stall_cnt got %0d want 3", stall_cnt); end
`endif
        ex_ready = 1'b1;
        #1;
        checks++; if (dec_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %0b want 1", dec_ready); end
        step();
        idle();
        checks++; if (ex_valid !== 1'b1 || A !== 32'd10 || B !== 32'd5 || alu_op !== 3'd4) begin
            errors++; $display("[TB] FAIL bp_release_load got v=%0b A=%0d B=%0d op=%0d want 1/10/5/4", ex_valid, A, B, alu_op);
        end
    endtask

    task automatic test_flush();
        issue(5'd3, 5'd3, 5'd11, 1'b0, 32'd0, ALU_OR, 1'b1);
        flush = 1'b1;
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'hDEAD_BEEF;
        step();
        idle();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %0b want 0", ex_valid); end
        issue(5'd4, 5'd3, 5'd12, 1'b0, 32'd0, ALU_OR, 1'b0);
        step();
        idle();
        checks++; if (ex_valid !== 1'b1 || A !== 32'hDEAD_BEEF || B !== 32'd10) begin
            errors++; $display("[TB] FAIL flush_wb_lands got v=%0b A=%08h B=%0d want 1/deadbeef/10", ex_valid, A, B);
        end
        step();
        checks++; if (ex_valid !== 1'b0 || A !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL drain_hold got v=%0b A=%08h want 0/deadbeef", ex_valid, A);
        end
    endtask

    task automatic test_x0();
        issue(5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 3'd6, 1'b1);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        step();
        idle();
        checks++; if (A !== 32'd0 || B !== 32'd0) begin errors++; $display("[TB] FAIL x0_same_cycle got A=%08h B=%08h want 0/0", A, B); end
        checks++; if (alu_op !== 3'd6) begin errors++; $display("[TB] FAIL op6_passthrough got %0d want 6", alu_op); end
        // In-flight op targets x0 with reg_we=1: its result must not be forwarded.
        issue(5'd0, 5'd0, 5'd1, 1'b0, 32'd0, 3'd7, 1'b0);
        alu_result = 32'h1234_5678;
        step();
        idle();
        checks++; if (A !== 32'd0 || B !== 32'd0 || alu_op !== 3'd7) begin
            errors++; $display("[TB] FAIL x0_no_fwd got A=%08h B=%08h op=%0d want 0/0/7", A, B, alu_op);
        end
    endtask

    task automatic test_priority();
        issue(5'd4, 5'd0, 5'd7, 1'b1, 32'd1, ALU_ADD, 1'b1);
        step();
        issue(5'd7, 5'd7, 5'd13, 1'b0, 32'd0, ALU_PASSB, 1'b0);
        alu_result = 32'd2;
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'd1;
        step();
        idle();
        checks++; if (A !== 32'd2 || B !== 32'd2) begin errors++; $display("[TB] FAIL ex_over_wb got A=%0d B=%0d want 2/2", A, B); end
        issue(5'd7, 5'd0, 5'd14, 1'b0, 32'd0, ALU_ADD, 1'b1);
        step();
        idle();
        checks++; if (A !== 32'd1 || B !== 32'd0) begin errors++; $display("[TB] FAIL rf_x7 got A=%0d B=%0d want 1/0", A, B); end
    endtask

    task automatic test_reset_mid();
        // ex_valid is 1 here from the previous issue.
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0 || A !== 32'd0 || B !== 32'd0 || ex_reg_we !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_mid got v=%0b A=%08h B=%08h we=%0b want 0/0/0/0", ex_valid, A, B, ex_reg_we);
        end
`ifdef ALU_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL reset_mid_stall_cnt got %0d want 0", stall_cnt); end
`endif
        step();
        rst_n = 1'b1;
        issue(5'd3, 5'd4, 5'd2, 1'b0, 32'd0, ALU_ADD, 1'b0);
        step();
        idle();
        checks++; if (ex_valid !== 1'b1 || A !== 32'd0 || B !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_rf_clear got v=%0b A=%08h B=%08h want 1/0/0", ex_valid, A, B);
        end
    endtask

    initial begin
        test_reset();
        test_wb_bypass();
        test_ex_forward();
        test_backpressure();
        test_flush();
        test_x0();
        test_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
